// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/add/shift ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), with registered result and flags.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int SLF_SHIFT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_ra,
    input  logic [WIDTH-1:0] s_rb,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rem,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH:0] W_ONE = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] W_LIM = (WIDTH + 1)'(WIDTH);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_rem;
    logic             r_fz, r_fn, r_fc, r_fv, r_fdz;

    logic [WIDTH:0]   w_res;
    logic             w_c;
    logic             w_v;
    logic             w_shamt_big;
    logic             w_is_iter;
    logic             w_is_div;
    logic             w_b_zero;

    assign w_shamt_big = ({1'b0, s_rb} >= W_LIM);
    assign w_is_iter   = op[3] & op[2] & op[0];
    assign w_is_div    = (op == 4'b1111);
    assign w_b_zero    = (s_rb == '0);

    // Single-cycle ops, evaluated at WIDTH+1 bits so carry/borrow land in the top bit
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op[2:0])
            3'b000: w_res = {1'b0, ~s_rb};
            3'b001: w_res = {1'b0, s_ra & s_rb};
            3'b010: w_res = {1'b0, s_ra | s_rb};
            3'b011: w_res = {1'b0, s_ra ^ s_rb};
            3'b100: begin
                if (op[3]) begin
                    w_res = {1'b0, s_rb} + W_ONE;
                    w_v   = ~s_rb[WIDTH-1] & w_res[WIDTH-1];
                end else begin
                    w_res = {1'b0, s_ra} + {1'b0, s_rb};
                    w_v   = (s_ra[WIDTH-1] == s_rb[WIDTH-1]) & (w_res[WIDTH-1] != s_ra[WIDTH-1]);
                end
                w_c = w_res[WIDTH];
            end
            3'b101: begin
                w_res = {1'b0, s_ra} - {1'b0, s_rb};
                w_c   = ~w_res[WIDTH];
                w_v   = (s_ra[WIDTH-1] != s_rb[WIDTH-1]) & (w_res[WIDTH-1] != s_ra[WIDTH-1]);
            end
            3'b110: begin
                if (op[3])
                    w_res = {1'b0, s_rb} << SLF_SHIFT;
                else if (!w_shamt_big)
                    w_res = {1'b0, s_ra} << s_rb;
            end
            3'b111: begin
                if (!w_shamt_big)
                    w_res = {1'b0, s_ra >> s_rb};
            end
            default: w_res = '0;
        endcase
    end

    // One iteration step; r_hi/r_lo hold product high/low or remainder/quotient
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

    always_comb begin
        if (r_div) begin
            w_hi_next = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_hi_next = w_mul_sum[WIDTH:1];
            w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_s     <= '0;
            r_rem   <= '0;
            r_fz    <= 1'b0;
            r_fn    <= 1'b0;
            r_fc    <= 1'b0;
            r_fv    <= 1'b0;
            r_fdz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_iter && !(w_is_div && w_b_zero)) begin
                            r_a     <= s_ra;
                            r_b     <= s_rb;
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? s_ra : s_rb;
                            r_div   <= w_is_div;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= ST_BUSY;
                        end else if (w_is_div) begin
                            r_s     <= '1;
                            r_rem   <= s_ra;
                            r_fz    <= 1'b0;
                            r_fn    <= 1'b1;
                            r_fc    <= 1'b0;
                            r_fv    <= 1'b0;
                            r_fdz   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_s     <= w_res[WIDTH-1:0];
                            r_rem   <= '0;
                            r_fz    <= (w_res[WIDTH-1:0] == '0);
                            r_fn    <= w_res[WIDTH-1];
                            r_fc    <= w_c;
                            r_fv    <= w_v;
                            r_fdz   <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_s     <= w_lo_next;
                        r_rem   <= r_div ? w_hi_next : '0;
                        r_fz    <= (w_lo_next == '0);
                        r_fn    <= w_lo_next[WIDTH-1];
                        r_fc    <= 1'b0;
                        r_fv    <= r_div ? 1'b0 : (w_hi_next != '0);
                        r_fdz   <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign s         = r_s;
    assign rem       = r_rem;
    assign flag_z    = r_fz;
    assign flag_n    = r_fn;
    assign flag_c    = r_fc;
    assign flag_v    = r_fv;
    assign flag_dz   = r_fdz;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed check of alu_seq (WIDTH=8) against an arithmetic
// reference model of each op, including latency and backpressure behaviour.
module tb_alu_seq;
    localparam int W = 8;
    localparam int M = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s_ra;
    logic [W-1:0] s_rb;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic [W-1:0] rem;
    logic         flag_z, flag_n, flag_c, flag_v, flag_dz;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W), .SLF_SHIFT(W / 2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s_ra     (s_ra),
        .s_rb     (s_rb),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .rem      (rem),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .flag_dz  (flag_dz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int x);
        return (x > 127) || (x < -128);
    endfunction

    // Reference: results derived directly from the op definitions with integer arithmetic
    task automatic model(input logic [3:0] o, input int a, input int b,
                         output int es, output int er, output int ec,
                         output int ev, output int edz, output int elat);
        int t;
        es = 0; er = 0; ec = 0; ev = 0; edz = 0; elat = 1;
        case (o)
            4'd0, 4'd8:  es = ~b & M;
            4'd1, 4'd9:  es = a & b;
            4'd2, 4'd10: es = a | b;
            4'd3, 4'd11: es = a ^ b;
            4'd4:  begin t = a + b; es = t & M; ec = int'(t > M); ev = int'(ovf(sx(a) + sx(b))); end
            4'd12: begin t = b + 1; es = t & M; ec = int'(t > M); ev = int'(ovf(sx(b) + 1)); end
            4'd5:  begin es = (a - b) & M; ec = int'(a >= b); ev = int'(ovf(sx(a) - sx(b))); end
            4'd6:  es = (b >= W) ? 0 : ((a << b) & M);
            4'd14: es = (b << (W / 2)) & M;
            4'd7:  es = (b >= W) ? 0 : (a >> b);
            4'd13: begin t = a * b; es = t & M; ev = int'((t >> W) != 0); elat = W + 1; end
            4'd15: begin
                if (b == 0) begin es = M; er = a; edz = 1; end
                else begin es = a / b; er = a % b; elat = W + 1; end
            end
            default: es = 0;
        endcase
    endtask

    // Caller is just after a negedge with the block idle
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit drain);
        int es, er, ec, ev, edz, elat, lat;
        model(o, int'(a), int'(b), es, er, ec, ev, edz, elat);
        check_eq("in_ready_before_issue", int'(in_ready), 1);
        in_valid  = 1'b1;
        op        = o;
        s_ra      = a;
        s_rb      = b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'($urandom);
        s_ra     = W'($urandom);
        s_rb     = W'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            out_ready = drain ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        $display("op=%b a=%02h b=%02h -> s=%02h rem=%02h z%b n%b c%b v%b dz%b lat=%0d",
                 o, a, b, s, rem, flag_z, flag_n, flag_c, flag_v, flag_dz, lat);
        check_eq("latency", lat, elat);
        check_eq("s", int'(s), es);
        check_eq("rem", int'(rem), er);
        check_eq("flag_z", int'(flag_z), int'(es == 0));
        check_eq("flag_n", int'(flag_n), (es >> (W - 1)) & 1);
        check_eq("flag_c", int'(flag_c), ec);
        check_eq("flag_v", int'(flag_v), ev);
        check_eq("flag_dz", int'(flag_dz), edz);
        if (drain) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; s_ra = '0; s_rb = '0;
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_s", int'(s), 0);
        check_eq("rst_flags", int'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'b0100, 8'hFF, 8'h01, 1'b1);
        run_op(4'b0101, 8'h80, 8'h01, 1'b1);

        // Reset while a MUL is in flight
        in_valid = 1'b1; op = 4'b1101; s_ra = 8'd13; s_rb = 8'd11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midmul_rst_out_valid", int'(out_valid), 0);
        check_eq("midmul_rst_s", int'(s), 0);
        check_eq("midmul_rst_rem", int'(rem), 0);
        check_eq("midmul_rst_in_ready", int'(in_ready), 1);
        check_eq("midmul_rst_flags", int'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        check_eq("midmul_no_result", int'(out_valid), 0);
        run_op(4'b0100, 8'h01, 8'h01, 1'b1);

        run_op(4'b1100, 8'h00, 8'h7F, 1'b1);
        run_op(4'b0110, 8'h01, 8'd9, 1'b1);
        run_op(4'b0111, 8'h80, 8'd7, 1'b1);
        run_op(4'b1110, 8'h00, 8'h0A, 1'b1);
        run_op(4'b1000, 8'h00, 8'h5A, 1'b1);
        run_op(4'b1101, 8'd15, 8'd17, 1'b1);
        run_op(4'b1101, 8'd16, 8'd16, 1'b1);
        run_op(4'b1101, 8'd0, 8'd200, 1'b1);
        run_op(4'b1111, 8'd200, 8'd7, 1'b1);
        run_op(4'b1111, 8'd5, 8'd0, 1'b1);

        // Backpressure: result must hold while the consumer stalls
        run_op(4'b0100, 8'd3, 8'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 4'b0101; s_ra = W'($urandom); s_rb = W'($urandom);
            @(negedge clk);
            check_eq("bp_out_valid", int'(out_valid), 1);
            check_eq("bp_in_ready", int'(in_ready), 0);
            check_eq("bp_s", int'(s), 7);
            check_eq("bp_flags", int'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_idle_in_ready", int'(in_ready), 1);
        check_eq("bp_idle_out_valid", int'(out_valid), 0);
        run_op(4'b0011, 8'hF0, 8'h3C, 1'b1);

        for (int n = 0; n < 300; n++) begin
            ro = 4'($urandom);
            ra = W'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = W'($urandom_range(0, 10));
                1:       rb = '0;
                default: rb = W'($urandom);
            endcase
            run_op(ro, ra, rb, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the processor's 8-bit combinational ULA.
- Keeps the existing 4-bit op encoding for the single-cycle ops. Adds iterative unsigned multiply and divide, a registered result, and registered Z/N/C/V/DZ flags.
- Sits between the register-file read stage and the writeback mux. The control unit issues one op at a time and stalls on in_ready/out_valid.

Parameters:
- WIDTH, 8: datapath width in bits. Must be even and >= 4.
- SLF_SHIFT, WIDTH/2: fixed left-shift amount for the SLF op (4 when WIDTH=8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are presented this cycle.
- in_ready  out  1  block accepts a new op (high only in IDLE).
- s_ra  in  WIDTH  operand A.
- s_rb  in  WIDTH  operand B.
- op  in  4  operation select (encoding below).
- out_valid  out  1  s, rem and flags hold a result.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  result (quotient for DIV).
- rem  out  WIDTH  remainder for DIV; 0 for all other ops.
- flag_z  out  1  s == 0.
- flag_n  out  1  s[WIDTH-1].
- flag_c  out  1  carry-out for ADD/INC; NOT borrow for SUB; 0 otherwise.
- flag_v  out  1  signed overflow for ADD/SUB/INC; for MUL, high product half nonzero; 0 otherwise.
- flag_dz  out  1  DIV with s_rb == 0.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, and s, rem and all flags = 0. A multi-cycle op in flight is abandoned; no result is produced.
- Op encoding (x = op[3] ignored):
  - x000 NOT B
  - x001 A AND B
  - x010 A OR B
  - x011 A XOR B
  - 0100 A+B
  - 1100 B+1
  - 0101 A-B
  - 0110 A<<B
  - 1110 B<<SLF_SHIFT
  - 0111 A>>B (logical)
  - 1101 MUL (low WIDTH bits of the unsigned product)
  - 1111 DIV (unsigned quotient; remainder on rem)
- Arithmetic: all ops are computed at WIDTH+1 bits internally and the result is truncated to WIDTH. Shifts by an amount >= WIDTH yield 0.
- Handshake: an op is accepted when in_valid && in_ready. s_ra, s_rb and op are captured on that edge; the inputs are don't-care afterwards.
- FSM, states IDLE / BUSY / DONE:
  - IDLE: on accept of a single-cycle op -> DONE. Result and flags are registered on the same edge, so out_valid rises 1 cycle after accept.
  - IDLE: on accept of MUL/DIV -> BUSY with the iteration counter loaded to WIDTH.
  - BUSY: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. The counter decrements each cycle. When the counter reaches 1, the final step is written and the next state is DONE. Total latency from accept to out_valid is WIDTH+1 cycles.
  - BUSY: in_ready=0 and out_valid=0.
  - DONE: out_valid=1, with s, rem and flags stable. When out_ready=1 -> IDLE.
  - DONE: in_ready=0, so back-to-back issue has a 1-cycle bubble. Accept in the same cycle as the drain is not allowed.
- DIV by zero: completes in 1 cycle (no BUSY) with s = all ones, rem = s_ra, flag_dz=1, flag_z=0, and flag_n set by the rule above (1 for all-ones s).
- MUL with either operand 0: still takes the full WIDTH+1 cycles, giving deterministic latency.
- Flags are registered together with s and are valid only while out_valid=1. They hold their values through IDLE until the next result overwrites them.
- out_ready held high while not in DONE: no effect.

Test Plan:
- Reset mid-MUL: issue MUL 13*11 (WIDTH=8), assert rst after 3 cycles -> out_valid=0, s=0, in_ready=1 immediately. A next ADD 1+1 returns s=2.
- Single-cycle ops:
  - ADD 0xFF+0x01 -> s=0x00, Z=1, C=1, V=0, 1-cycle latency.
  - SUB 0x80-0x01 -> s=0x7F, V=1, C=1.
  - INC B=0x7F -> s=0x80, N=1, V=1.
- Shifts and logic:
  - SHL 0x01<<9 -> s=0.
  - SHR 0x80>>7 -> s=0x01.
  - SLF B=0x0A -> s=0xA0.
  - NOT with op=1000 -> s=~B.
- MUL:
  - 15*17 -> s=0xFF, V=0, out_valid exactly 9 cycles after accept.
  - 16*16 -> s=0x00, Z=1, V=1.
- DIV:
  - 200/7 -> s=28, rem=4, latency 9.
  - 5/0 -> s=0xFF, rem=5, DZ=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> s and flags stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> IDLE next cycle; the next op is accepted the following cycle.
